// File: rtl/video_timing_pkg.sv
// video_timing_pkg: raster timing constants for the supported video modes
package video_timing_pkg;
    localparam int CNT_W_480P    = 10;
    localparam int H_ACTIVE_480P = 640;
    localparam int H_FP_480P     = 16;
    localparam int H_SYNC_480P   = 96;
    localparam int H_BP_480P     = 48;
    localparam int V_ACTIVE_480P = 480;
    localparam int V_FP_480P     = 10;
    localparam int V_SYNC_480P   = 2;
    localparam int V_BP_480P     = 33;
    localparam int H_TOTAL_480P  = H_ACTIVE_480P + H_FP_480P + H_SYNC_480P + H_BP_480P;
    localparam int V_TOTAL_480P  = V_ACTIVE_480P + V_FP_480P + V_SYNC_480P + V_BP_480P;
    localparam int H_SYNC_START_480P = H_ACTIVE_480P + H_FP_480P;
    localparam int H_SYNC_END_480P   = H_SYNC_START_480P + H_SYNC_480P;
    localparam int V_SYNC_START_480P = V_ACTIVE_480P + V_FP_480P;
    localparam int V_SYNC_END_480P   = V_SYNC_START_480P + V_SYNC_480P;
endpackage

// File: rtl/video_timing_480p_sync.sv
// sync_2ff: two-flop synchroniser, clears to 0 on reset
module sync_2ff (
    input  logic PCLK,
    input  logic RESET_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge PCLK or negedge RESET_n)
        if (!RESET_n) {q, meta} <= 2'b00;
        else          {q, meta} <= {meta, d};
endmodule

// File: rtl/video_timing_480p.sv
// video_timing_480p: raster timing generator, idle until the pixel PLL is locked
module video_timing_480p
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_480P,
    parameter int   H_FP     = H_FP_480P,
    parameter int   H_SYNC   = H_SYNC_480P,
    parameter int   H_BP     = H_BP_480P,
    parameter int   V_ACTIVE = V_ACTIVE_480P,
    parameter int   V_FP     = V_FP_480P,
    parameter int   V_SYNC   = V_SYNC_480P,
    parameter int   V_BP     = V_BP_480P,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CNT_W    = CNT_W_480P
) (
    input  logic             PCLK,
    input  logic             RESET_n,
    input  logic             PLOCK,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             LINE_START,
    output logic             FRAME_START
);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_S   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_S   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    logic             lock_s;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             de_c, hsync_c, vsync_c, h_wrap;
    sync_2ff u_lock_sync (
        .PCLK    (PCLK),
        .RESET_n (RESET_n),
        .d       (PLOCK),
        .q       (lock_s)
    );
    always_comb begin
        h_wrap  = hcnt == H_LAST;
        de_c    = hcnt < H_ACT && vcnt < V_ACT;
        hsync_c = hcnt >= HS_S && hcnt < HS_E;
        vsync_c = vcnt >= VS_S && vcnt < VS_E;
    end
    // Losing lock forces counters and outputs back to their reset values on the next edge.
    always_ff @(posedge PCLK or negedge RESET_n)
        if (!RESET_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            HSYNC       <= ~H_POL;
            VSYNC       <= ~V_POL;
            DE          <= 1'b0;
            X           <= '0;
            Y           <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            hcnt        <= !lock_s || h_wrap ? '0 : hcnt + 1'b1;
            vcnt        <= !lock_s ? '0 : !h_wrap ? vcnt : vcnt == V_LAST ? '0 : vcnt + 1'b1;
            HSYNC       <= lock_s && hsync_c ? H_POL : ~H_POL;
            VSYNC       <= lock_s && vsync_c ? V_POL : ~V_POL;
            DE          <= lock_s && de_c;
            X           <= lock_s ? hcnt : '0;
            Y           <= lock_s ? vcnt : '0;
            LINE_START  <= lock_s && hcnt == '0;
            FRAME_START <= lock_s && hcnt == '0 && vcnt == '0;
        end
endmodule

// File: tb/tb_video_timing_480p.sv
// tb_video_timing_480p: directed checks of 480p timing, inverted polarity and a scaled-down raster
module tb_video_timing_480p;
    logic       PCLK = 1'b0;
    logic       RESET_n, PLOCK;
    logic       hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1, hss, vss, des, lss, fss;
    logic [9:0] x0, y0, x1, y1;
    logic [3:0] xs, ys;
    int         vectors = 0, miscompares = 0;
    int         mx, my, sx, sy;
    int         de_line = 0, hs_low = 0, de_frame_s = 0, vs_low_s = 0, last_ls = 0, last_fs = 0;

    always #5 PCLK = ~PCLK;

    video_timing_480p d0 (.PCLK(PCLK), .RESET_n(RESET_n), .PLOCK(PLOCK), .HSYNC(hs0), .VSYNC(vs0),
        .DE(de0), .X(x0), .Y(y0), .LINE_START(ls0), .FRAME_START(fs0));
    video_timing_480p #(.H_POL(1'b1), .V_POL(1'b1)) d1 (.PCLK(PCLK), .RESET_n(RESET_n), .PLOCK(PLOCK),
        .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .X(x1), .Y(y1), .LINE_START(ls1), .FRAME_START(fs1));
    video_timing_480p #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .CNT_W(4)) ds (.PCLK(PCLK), .RESET_n(RESET_n), .PLOCK(PLOCK),
        .HSYNC(hss), .VSYNC(vss), .DE(des), .X(xs), .Y(ys), .LINE_START(lss), .FRAME_START(fss));

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_d0"}, {hs0, vs0, de0, ls0, fs0, x0, y0}, {5'b11000, 20'd0});
        chk({tag, "_d1"}, {hs1, vs1, de1, ls1, fs1, x1, y1}, {5'b00000, 20'd0});
        chk({tag, "_s"},  {hss, vss, des, lss, fss, xs, ys}, {5'b11000, 8'd0});
    endtask

    // Expected outputs for the raster position the model currently holds.
    task automatic chk_run(input string tag);
        logic h, v, d, hs_s, vs_s, d_s;
        h    = !(mx >= 656 && mx < 752);
        v    = !(my >= 490 && my < 492);
        d    = mx < 640 && my < 480;
        hs_s = !(sx >= 5 && sx < 7);
        vs_s = !(sy >= 4 && sy < 6);
        d_s  = sx < 4 && sy < 3;
        chk({tag, "_d0"}, {hs0, vs0, de0, ls0, fs0, x0, y0},
            {h, v, d, mx == 0, mx == 0 && my == 0, 10'(mx), 10'(my)});
        chk({tag, "_d1"}, {hs1, vs1, de1, ls1, fs1, x1, y1},
            {~h, ~v, d, mx == 0, mx == 0 && my == 0, 10'(mx), 10'(my)});
        chk({tag, "_s"}, {hss, vss, des, lss, fss, xs, ys},
            {hs_s, vs_s, d_s, sx == 0, sx == 0 && sy == 0, 4'(sx), 4'(sy)});
    endtask

    task automatic advance();
        if (mx == 799) begin
            mx = 0;
            my = my == 524 ? 0 : my + 1;
        end else mx++;
        if (sx == 7) begin
            sx = 0;
            sy = sy == 6 ? 0 : sy + 1;
        end else sx++;
    endtask

    initial begin
        RESET_n = 1'b0;
        PLOCK   = 1'b1;
        repeat (4) begin tick(); chk_idle("in_reset"); end
        PLOCK = 1'b0;
        tick();
        RESET_n = 1'b1;
        repeat (4) begin tick(); chk_idle("unlocked"); end
        PLOCK = 1'b1;
        repeat (2) begin tick(); chk_idle("lock_sync"); end
        mx = 0; my = 0; sx = 0; sy = 0;
        for (int i = 0; i < 2701; i++) begin
            tick();
            chk_run("run");
            if (i < 800) begin
                de_line += int'(de0);
                hs_low  += int'(!hs0);
            end
            if (i < 56) begin
                de_frame_s += int'(des);
                vs_low_s   += int'(!vss);
            end
            if (ls0 && i > 0) chk("line_period", i - last_ls, 800);
            if (ls0) last_ls = i;
            if (fss && i > 0) chk("frame_period_s", i - last_fs, 56);
            if (fss) last_fs = i;
            advance();
        end
        chk("de_per_line", de_line, 640);
        chk("hsync_low_per_line", hs_low, 96);
        chk("de_per_frame_s", de_frame_s, 12);
        chk("vsync_low_per_frame_s", vs_low_s, 16);
        PLOCK = 1'b0;
        repeat (2) begin tick(); chk_run("lock_drop_pipe"); advance(); end
        repeat (48) begin tick(); chk_idle("lock_lost"); end
        PLOCK = 1'b1;
        repeat (2) begin tick(); chk_idle("relock_sync"); end
        mx = 0; my = 0; sx = 0; sy = 0;
        repeat (20) begin tick(); chk_run("relock"); advance(); end
        RESET_n = 1'b0;
        #1;
        chk_idle("async_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
